bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter with a prescaler. It is the countdown counterpart of the team's up-counting BCD digit counters.
- The host loads a BCD value, then starts, pauses and resumes the countdown. The block signals completion when the count reaches zero.
- The digits output is meant to feed the same display path the up-counters drive.

Parameters:
- DIGITS, 2, number of BCD digits (digit 0 = units, least significant).
- TICK_DIV, 5, clocks per decrement (prescaler modulus); legal range 1..256.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_value into the count.
- load_value  input  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
- start  input  1  begin or resume countdown.
- pause  input  1  suspend countdown.
- digits  output  4*DIGITS  current BCD count.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the count reaches zero.
- zero  output  1  high when all digits equal 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: digits=0, state=IDLE, prescaler=0, running=0, done=0.
- zero is combinational from the registered count.
- Reset dominates all inputs, including mid-count; all state is cleared on that edge.
- States:
  - IDLE: holding the count.
  - RUN: counting down.
  - PAUSED: count and prescaler frozen.
  - DONE: one cycle only; done=1.
- Input priority per edge: reset > load > pause > start.
- load, in any state:
  - count <= load_value, with any digit >9 clamped to 9.
  - prescaler <= 0; state <= IDLE; a pending done is cancelled.
- IDLE + start:
  - If count != 0: state <= RUN, prescaler <= 0.
  - If count == 0: state <= DONE (done pulse next cycle, count unchanged).
- RUN, on each edge:
  - If prescaler == TICK_DIV-1: prescaler <= 0 and the count decrements. Otherwise prescaler increments.
  - The first decrement lands on the TICK_DIV-th edge after the start edge.
  - TICK_DIV=1 decrements every edge.
- Decrement arithmetic:
  - Per-digit BCD borrow chain: a digit at 0 with borrow-in becomes 9 and propagates the borrow; otherwise it decrements by 1.
  - Only digit 0 receives an unconditional borrow-in.
- Terminal count:
  - When a decrement produces all-zero, state <= DONE on that edge.
  - done is high for exactly the following cycle; then state <= IDLE.
  - The count never wraps below 0.
- RUN + pause: state <= PAUSED. Prescaler and count hold.
- PAUSED + start (pause low): state <= RUN, continuing from the held prescaler value.
- pause in IDLE or PAUSED: no effect.
- start in RUN or DONE: ignored.
- running = (state == RUN).

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - The block stores the last loaded value (post-clamp) in a reload register.
  - On terminal count: done pulses, count <= reload value, and state stays RUN (no DONE/IDLE visit), unless the reload value is 0, in which case normal DONE behaviour applies.
  - The reload register resets to 0.
- Undefined: no reload register is present; the countdown stops at 0 as described above.

Decomposition:
- Shared package bcd_timer_pkg:
  - State enum: IDLE, RUN, PAUSED, DONE.
  - BCD_MAX = 4'd9, BCD_ZERO = 4'd0.
  - Digit width constant BCD_W = 4.
- Sub-module bcd_down_digit: one digit with clamp-on-load, borrow_in, borrow_out and is_zero, instantiated DIGITS times via generate.

Test Plan:
- reset mid-RUN at count 37 -> next cycle digits=00, running=0, done=0, zero=1.
- load 8'h03, start, TICK_DIV=5 -> digits 02/01/00 on the 5th/10th/15th edges after start; done high exactly one cycle after the 15th edge; then IDLE.
- load 8'h10, run one tick -> digits=09 (borrow across digits); load 8'hAF -> digits=99 (clamp).
- RUN at 8'h05, pause at prescaler=2 for 7 cycles, then start -> count held at 05 during pause; next decrement 3 edges after resume.
- load and start asserted together with value 8'h20 -> digits=20, state IDLE, running=0.
- start with count 00 -> done pulses one cycle, digits stay 00.
- With BCD_TIMER_AUTO_RELOAD_EN: load 8'h02, start -> done pulses every 10 edges, digits cycle 02,01,02..., running stays 1.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_ZERO = 4'd0;

  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_timer_digit.sv
// Single BCD down-counting digit: clamp-on-load, borrow chain in/out.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_value,
  input  logic             dec,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out,
  output logic             is_zero
);

  always_ff @(posedge clk) begin
    if (reset)
      digit <= '0;
    else if (load)
      digit <= clamp_bcd(load_value);
    else if (dec && borrow_in)
      digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
  end

  assign is_zero    = (digit == BCD_ZERO);
  assign borrow_out = borrow_in && is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with prescaler and start/pause control.
// Optional auto-reload on terminal count: define BCD_TIMER_AUTO_RELOAD_EN.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_DIV = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                done,
  output logic                zero
);

  localparam logic [7:0] PRE_MAX = 8'(TICK_DIV - 1);

  state_t              state, state_n;
  logic [7:0]          pre, pre_n;
  logic                tick, reload_now, count_is_one, done_r;
  logic [DIGITS:0]     borrow;
  logic [DIGITS-1:0]   is_zero_v;
  logic [4*DIGITS-1:0] digit_src;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [4*DIGITS-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (reset)
      reload_q <= '0;
    else if (load)
      for (int unsigned i = 0; i < DIGITS; i++)
        reload_q[4*i +: 4] <= clamp_bcd(load_value[4*i +: 4]);
  end

  assign digit_src = load ? load_value : reload_q;
`else
  assign digit_src = load_value;
`endif

  // Borrow into the last digit's output means the count is already zero;
  // gating on it keeps the count from ever wrapping.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load | reload_now),
      .load_value (digit_src[4*g +: 4]),
      .dec        (tick & ~borrow[DIGITS]),
      .borrow_in  (borrow[g]),
      .digit      (digits[4*g +: 4]),
      .borrow_out (borrow[g+1]),
      .is_zero    (is_zero_v[g])
    );
  end

  assign zero = &is_zero_v;

  always_comb begin
    count_is_one = (digits[3:0] == 4'd1);
    for (int unsigned i = 1; i < DIGITS; i++)
      if (!is_zero_v[i]) count_is_one = 1'b0;
  end

  always_comb begin
    state_n    = state;
    pre_n      = pre;
    tick       = 1'b0;
    reload_now = 1'b0;
    if (load) begin
      state_n = IDLE;
      pre_n   = '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            pre_n   = '0;
            state_n = zero ? DONE : RUN;
          end
        RUN:
          if (pause) begin
            state_n = PAUSED;
          end else if (pre == PRE_MAX) begin
            pre_n = '0;
            tick  = 1'b1;
            if (count_is_one) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
              if (reload_q != '0) reload_now = 1'b1;
              else                state_n    = DONE;
`else
              state_n = DONE;
`endif
            end
          end else begin
            pre_n = pre + 8'd1;
          end
        PAUSED:
          if (start && !pause) state_n = RUN;
        DONE:
          state_n = IDLE;
        default:
          state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pre    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      pre    <= pre_n;
      done_r <= (state_n == DONE) || reload_now;
    end
  end

  assign running = (state == RUN);
  assign done    = done_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (DIGITS=2, TICK_DIV=5).
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, pause;
  logic [7:0] load_value;
  logic [7:0] digits;
  logic       running, done, zero;

  bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .digits     (digits),
    .running    (running),
    .done       (done),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [7:0]  digits;
    logic        running;
    logic        done;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every negedge, pop and compare all expectations due now.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_cmp++;
        if (digits !== sb[i].digits || running !== sb[i].running ||
            done !== sb[i].done || zero !== sb[i].zero) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got digits=%h run=%b done=%b zero=%b, want digits=%h run=%b done=%b zero=%b",
                   sb[i].name, cyc, digits, running, done, zero,
                   sb[i].digits, sb[i].running, sb[i].done, sb[i].zero);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation for cyc %0d overdue at cyc %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input string name, input int unsigned off, input logic [7:0] d,
                           input logic r, input logic dn, input logic z);
    exp_t e;
    e.name = name; e.cyc = cyc + off; e.digits = d; e.running = r; e.done = dn; e.zero = z;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; load_value = '0;
    step(2);
    expect_at("reset_state", 0, 8'h00, 0, 0, 1);
    reset = 1'b0;
    step(2);

    // 03 countdown: decrements on 5th/10th/15th edge after start, done after 15th
    do_load(8'h03);
    expect_at("load_03", 0, 8'h03, 0, 0, 0);
    do_start();
    expect_at("run_start", 0, 8'h03, 1, 0, 0);
    expect_at("pre_edge4", 4, 8'h03, 1, 0, 0);
    expect_at("dec_edge5", 5, 8'h02, 1, 0, 0);
    expect_at("hold_edge9", 9, 8'h02, 1, 0, 0);
    expect_at("dec_edge10", 10, 8'h01, 1, 0, 0);
    expect_at("hold_edge14", 14, 8'h01, 1, 0, 0);
    expect_at("done_edge15", 15, 8'h00, 0, 1, 1);
    expect_at("idle_edge16", 16, 8'h00, 0, 0, 1);
    expect_at("idle_edge17", 17, 8'h00, 0, 0, 1);
    step(18);

    // Borrow across digits, then clamp on load during RUN
    do_load(8'h10);
    do_start();
    expect_at("borrow_10_09", 5, 8'h09, 1, 0, 0);
    step(6);
    do_load(8'hAF);
    expect_at("clamp_AF", 0, 8'h99, 0, 0, 0);
    step(2);

    // Pause at prescaler=2 for 7 cycles, resume, decrement 3 edges later
    do_load(8'h05);
    do_start();
    step(2);
    pause = 1'b1;
    step();
    expect_at("paused_0", 0, 8'h05, 0, 0, 0);
    step(6);
    expect_at("paused_6", 0, 8'h05, 0, 0, 0);
    pause = 1'b0;
    do_start();
    expect_at("resume", 0, 8'h05, 1, 0, 0);
    expect_at("resume_e2", 2, 8'h05, 1, 0, 0);
    expect_at("resume_e3", 3, 8'h04, 1, 0, 0);
    step(4);

    // Reset mid-RUN at 37
    do_load(8'h37);
    do_start();
    step(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_at("reset_midrun", 0, 8'h00, 0, 0, 1);
    expect_at("reset_after", 1, 8'h00, 0, 0, 1);
    step(2);

    // load and start together: load wins
    load = 1'b1; start = 1'b1; load_value = 8'h20;
    step();
    load = 1'b0; start = 1'b0;
    expect_at("load_start_20", 0, 8'h20, 0, 0, 0);
    expect_at("load_start_20b", 1, 8'h20, 0, 0, 0);
    step(2);

    // start with count 00: one done pulse, digits stay 00
    do_load(8'h00);
    do_start();
    expect_at("zero_start_done", 0, 8'h00, 0, 1, 1);
    expect_at("zero_start_idle", 1, 8'h00, 0, 0, 1);
    step(3);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    do_load(8'h02);
    do_start();
    expect_at("ar_dec1", 5, 8'h01, 1, 0, 0);
    expect_at("ar_reload1", 10, 8'h02, 1, 1, 0);
    expect_at("ar_after1", 11, 8'h02, 1, 0, 0);
    expect_at("ar_dec2", 15, 8'h01, 1, 0, 0);
    expect_at("ar_reload2", 20, 8'h02, 1, 1, 0);
    expect_at("ar_after2", 21, 8'h02, 1, 0, 0);
    step(23);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_cmp += sb.size();
      n_bad += sb.size();
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
